// File: rtl/efa_pkg.sv
// Shared definitions for the EFA LUT write path: LUT select codes, loader states
// and the bit layout of the frame header and length words.
package efa_pkg;

  localparam int RAM_SEL_W = 6;

  localparam logic [RAM_SEL_W-1:0] RAM_SEL_SCAL = 6'd4;
  localparam logic [RAM_SEL_W-1:0] RAM_SEL_TEMP = 6'd5;

  localparam int HDR_SEL_MSB  = 15;
  localparam int HDR_SEL_LSB  = 10;
  localparam int HDR_ADDR_MSB = 7;
  localparam int HDR_ADDR_LSB = 0;
  localparam int LEN_MSB      = 7;
  localparam int LEN_LSB      = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } loader_state_t;

  function automatic logic is_lut_sel(input logic [RAM_SEL_W-1:0] sel);
    return (sel == RAM_SEL_SCAL) || (sel == RAM_SEL_TEMP);
  endfunction

endpackage

// File: rtl/efa_lut_loader.sv
// Turns a framed host word stream (HDR, LEN, N data words, XOR checksum) into
// single-cycle writes on the shared EFA LUT external-write bus.
module efa_lut_loader
  import efa_pkg::*;
#(
  parameter int SCAL_ADDR_LEN = 8,
  parameter int TEMP_ADDR_LEN = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SCAL_ADDR_LEN+TEMP_ADDR_LEN-1:0] s_data,
  input  logic                          stall,
  input  logic                          abort,
  output logic                          we,
  output logic [RAM_SEL_W-1:0]          ram_sel,
  output logic [(SCAL_ADDR_LEN+TEMP_ADDR_LEN)/2-1:0] ext_wr_addr,
  output logic [SCAL_ADDR_LEN+TEMP_ADDR_LEN-1:0] ext_din,
  output logic                          busy,
  output logic                          done,
  output logic                          csum_err,
  output logic                          sel_err,
  output logic [7:0]                    frame_cnt
);

  localparam int T_FIX_WID = SCAL_ADDR_LEN + TEMP_ADDR_LEN;
  localparam int AW        = T_FIX_WID / 2;

  loader_state_t        state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [T_FIX_WID-1:0] xor_q, xor_d;
  logic                 sel_ok_q, sel_ok_d;

  logic                 we_q, we_d;
  logic [RAM_SEL_W-1:0] ram_sel_q, ram_sel_d;
  logic [AW-1:0]        ext_wr_addr_q, ext_wr_addr_d;
  logic [T_FIX_WID-1:0] ext_din_q, ext_din_d;
  logic                 done_q, done_d;
  logic                 csum_err_q, csum_err_d;
  logic                 sel_err_q, sel_err_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;

  logic                 accept_s;
  logic [RAM_SEL_W-1:0] hdr_sel_s;

  assign s_ready   = ~stall & ~abort;
  assign accept_s  = s_valid & s_ready;
  assign hdr_sel_s = s_data[HDR_SEL_MSB:HDR_SEL_LSB];

  // Next-state for the frame FSM, datapath counters and output registers.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    xor_d         = xor_q;
    sel_ok_d      = sel_ok_q;
    we_d          = 1'b0;
    ram_sel_d     = ram_sel_q;
    ext_wr_addr_d = ext_wr_addr_q;
    ext_din_d     = ext_din_q;
    done_d        = 1'b0;
    csum_err_d    = 1'b0;
    sel_err_d     = sel_err_q;
    frame_cnt_d   = frame_cnt_q;

    if (abort) begin
      state_d = IDLE;
    end else if (accept_s) begin
      case (state_q)
        IDLE: begin
          ram_sel_d = hdr_sel_s;
          addr_d    = s_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
          sel_ok_d  = is_lut_sel(hdr_sel_s);
          sel_err_d = ~is_lut_sel(hdr_sel_s);
          xor_d     = '0;
          state_d   = LEN;
        end
        LEN: begin
          cnt_d   = s_data[LEN_MSB:LEN_LSB];
          state_d = DATA;
        end
        DATA: begin
          xor_d  = xor_q ^ s_data;
          addr_d = addr_q + 1'b1;
          // Bad-select frames are still consumed, but the bus is left untouched.
          if (sel_ok_q) begin
            we_d          = 1'b1;
            ext_din_d     = s_data;
            ext_wr_addr_d = addr_q;
          end else begin
            we_d          = 1'b0;
          end
          if (cnt_q == '0) begin
            state_d = CSUM;
          end else begin
            cnt_d   = cnt_q - 1'b1;
          end
        end
        CSUM: begin
          done_d      = 1'b1;
          csum_err_d  = (xor_q != s_data);
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      xor_q         <= '0;
      sel_ok_q      <= 1'b0;
      we_q          <= 1'b0;
      ram_sel_q     <= '0;
      ext_wr_addr_q <= '0;
      ext_din_q     <= '0;
      done_q        <= 1'b0;
      csum_err_q    <= 1'b0;
      sel_err_q     <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      xor_q         <= xor_d;
      sel_ok_q      <= sel_ok_d;
      we_q          <= we_d;
      ram_sel_q     <= ram_sel_d;
      ext_wr_addr_q <= ext_wr_addr_d;
      ext_din_q     <= ext_din_d;
      done_q        <= done_d;
      csum_err_q    <= csum_err_d;
      sel_err_q     <= sel_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign we          = we_q;
  assign ram_sel     = ram_sel_q;
  assign ext_wr_addr = ext_wr_addr_q;
  assign ext_din     = ext_din_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign csum_err    = csum_err_q;
  assign sel_err     = sel_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_efa_lut_loader.sv
// Directed bench for efa_lut_loader: frames, wrap, checksum error, bad select,
// stall, abort and async reset, with LUT writes captured by a bus monitor.
module tb_efa_lut_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = 16'h0000;
  logic        stall = 1'b0;
  logic        abort = 1'b0;
  logic        we;
  logic [5:0]  ram_sel;
  logic [7:0]  ext_wr_addr;
  logic [15:0] ext_din;
  logic        busy, done, csum_err, sel_err;
  logic [7:0]  frame_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  wa[$];
  logic [15:0] wd[$];
  int          wc[$];

  efa_lut_loader dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .stall(stall), .abort(abort), .we(we),
    .ram_sel(ram_sel), .ext_wr_addr(ext_wr_addr), .ext_din(ext_din),
    .busy(busy), .done(done), .csum_err(csum_err), .sel_err(sel_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wa.push_back(ext_wr_addr);
      wd.push_back(ext_din);
      wc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word for exactly one rising edge; returns on the following falling edge.
  task automatic send(input logic [15:0] w);
    s_valid = 1'b1;
    s_data  = w;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic clear_writes();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic chk_write(input string tag, input int i, input logic [7:0] a, input logic [15:0] d);
    if (i < wa.size()) begin
      chk({tag, "_addr"}, 32'(wa[i]), 32'(a));
      chk({tag, "_data"}, 32'(wd[i]), 32'(d));
    end else begin
      chk({tag, "_missing"}, 32'(wa.size()), 32'(i + 1));
    end
  endtask

  task automatic chk_consecutive(input string tag);
    for (int i = 1; i < wc.size(); i++) begin
      chk(tag, 32'(wc[i] - wc[i-1]), 32'd1);
    end
  endtask

  initial begin
    #2;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_ram_sel", 32'(ram_sel), 32'd0);
    chk("rst_addr", 32'(ext_wr_addr), 32'd0);
    chk("rst_din", 32'(ext_din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_csum_err", 32'(csum_err), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(s_ready), 32'd1);
    @(negedge clk);

    // Frame 1: sel4 at addr 3, three words, good checksum
    clear_writes();
    send(16'h1003);
    chk("f1_busy", 32'(busy), 32'd1);
    chk("f1_ram_sel", 32'(ram_sel), 32'd4);
    send(16'h0002);
    send(16'h1111);
    send(16'h2222);
    send(16'h4444);
    send(16'h7777);
    chk("f1_done", 32'(done), 32'd1);
    chk("f1_csum_err", 32'(csum_err), 32'd0);
    chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("f1_busy_end", 32'(busy), 32'd0);
    chk("f1_nwrites", 32'(wa.size()), 32'd3);
    chk_write("f1_w0", 0, 8'h03, 16'h1111);
    chk_write("f1_w1", 1, 8'h04, 16'h2222);
    chk_write("f1_w2", 2, 8'h05, 16'h4444);
    chk_consecutive("f1_consecutive");

    // Frame 2 back-to-back: sel5 at 0xFE, four words wrapping the address
    clear_writes();
    send(16'h14FE);
    chk("f2_done_cleared", 32'(done), 32'd0);
    chk("f2_ram_sel", 32'(ram_sel), 32'd5);
    send(16'h0003);
    send(16'h0001);
    send(16'h0002);
    send(16'h0004);
    send(16'h0008);
    send(16'h000F);
    chk("f2_done", 32'(done), 32'd1);
    chk("f2_csum_err", 32'(csum_err), 32'd0);
    chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("f2_nwrites", 32'(wa.size()), 32'd4);
    chk_write("f2_w0", 0, 8'hFE, 16'h0001);
    chk_write("f2_w1", 1, 8'hFF, 16'h0002);
    chk_write("f2_w2", 2, 8'h00, 16'h0004);
    chk_write("f2_w3", 3, 8'h01, 16'h0008);
    @(negedge clk);
    chk("f2_done_pulse", 32'(done), 32'd0);
    chk("f2_ram_sel_hold", 32'(ram_sel), 32'd5);
    chk("f2_addr_hold", 32'(ext_wr_addr), 32'h01);

    // Frame 3: bad checksum, writes still happen
    clear_writes();
    send(16'h1003);
    send(16'h0002);
    send(16'h1111);
    send(16'h2222);
    send(16'h4444);
    send(16'h0000);
    chk("f3_done", 32'(done), 32'd1);
    chk("f3_csum_err", 32'(csum_err), 32'd1);
    chk("f3_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("f3_nwrites", 32'(wa.size()), 32'd3);
    chk_write("f3_w2", 2, 8'h05, 16'h4444);
    @(negedge clk);
    chk("f3_csum_err_pulse", 32'(csum_err), 32'd0);

    // Frame 4: ram_sel=7 is consumed silently with sel_err
    clear_writes();
    send(16'h1C10);
    chk("f4_sel_err", 32'(sel_err), 32'd1);
    chk("f4_ram_sel", 32'(ram_sel), 32'd7);
    send(16'h0001);
    send(16'hAAAA);
    send(16'h5555);
    send(16'hFFFF);
    chk("f4_done", 32'(done), 32'd1);
    chk("f4_csum_err", 32'(csum_err), 32'd0);
    chk("f4_frame_cnt", 32'(frame_cnt), 32'd4);
    chk("f4_nwrites", 32'(wa.size()), 32'd0);
    chk("f4_sel_err_sticky", 32'(sel_err), 32'd1);
    chk("f4_din_hold", 32'(ext_din), 32'h4444);

    // Frame 5: valid header clears sel_err; stall for 3 cycles mid-DATA
    clear_writes();
    send(16'h1020);
    chk("f5_sel_err_clear", 32'(sel_err), 32'd0);
    send(16'h0003);
    send(16'h0101);
    send(16'h0202);
    stall   = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h0404;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("f5_stall_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
    end
    chk("f5_stall_nwrites", 32'(wa.size()), 32'd2);
    chk("f5_stall_we", 32'(we), 32'd0);
    stall = 1'b0;
    send(16'h0404);
    send(16'h0808);
    send(16'h0F0F);
    chk("f5_done", 32'(done), 32'd1);
    chk("f5_csum_err", 32'(csum_err), 32'd0);
    chk("f5_frame_cnt", 32'(frame_cnt), 32'd5);
    chk("f5_nwrites", 32'(wa.size()), 32'd4);
    chk_write("f5_w1", 1, 8'h21, 16'h0202);
    chk_write("f5_w2", 2, 8'h22, 16'h0404);
    chk_write("f5_w3", 3, 8'h23, 16'h0808);

    // Frame 6: abort after the second data word, with s_valid also high
    clear_writes();
    send(16'h1040);
    send(16'h0003);
    send(16'h0001);
    send(16'h0002);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h1234;
    #1;
    chk("f6_abort_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("f6_busy", 32'(busy), 32'd0);
    chk("f6_done", 32'(done), 32'd0);
    chk("f6_we", 32'(we), 32'd0);
    chk("f6_frame_cnt", 32'(frame_cnt), 32'd5);
    chk("f6_nwrites", 32'(wa.size()), 32'd2);

    // Frame 7: fresh single-word frame after abort
    clear_writes();
    send(16'h1050);
    send(16'h0000);
    send(16'hBEEF);
    send(16'hBEEF);
    chk("f7_done", 32'(done), 32'd1);
    chk("f7_csum_err", 32'(csum_err), 32'd0);
    chk("f7_frame_cnt", 32'(frame_cnt), 32'd6);
    chk("f7_nwrites", 32'(wa.size()), 32'd1);
    chk_write("f7_w0", 0, 8'h50, 16'hBEEF);

    // Async reset mid-DATA
    send(16'h1060);
    send(16'h0003);
    send(16'h0001);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_we", 32'(we), 32'd0);
    chk("ar_ram_sel", 32'(ram_sel), 32'd0);
    chk("ar_addr", 32'(ext_wr_addr), 32'd0);
    chk("ar_din", 32'(ext_din), 32'd0);
    chk("ar_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Frame 8: loads correctly after reset
    clear_writes();
    send(16'h1403);
    send(16'h0001);
    send(16'h00F0);
    send(16'h000F);
    send(16'h00FF);
    chk("f8_done", 32'(done), 32'd1);
    chk("f8_csum_err", 32'(csum_err), 32'd0);
    chk("f8_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("f8_nwrites", 32'(wa.size()), 32'd2);
    chk_write("f8_w0", 0, 8'h03, 16'h00F0);
    chk_write("f8_w1", 1, 8'h04, 16'h000F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
